axis_fifo: RTL and testbench

Receive-side counterpart of the FIFO-to-AXI-stream reader. Accepts a 128-bit AXI4-Stream (slave side), reverses the 32-bit word order of each beat, and writes the beats into a standard (non-show-ahead) FIFO write port that honours `full`. A registered output stage plus a one-entry skid buffer keep `s_tready` a pure flop output, with no combinational path from `full`. Sits between upstream stream producers and the clock-crossing FIFOs feeding the stream reader.

---
 rtl/axis_fifo.sv | 128 ++++++++++++
 tb/tb_axis_fifo.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - AXI-Stream slave to FIFO write port with lane swap and skid buffer
//
// Purpose: accepts 128-bit (C_DATA_W) AXI-Stream beats, reverses the 32-bit
// lane order of each beat, and writes them into a standard FIFO write port
// that honours full. s_tready is a pure flop output: a one-entry skid
// buffer absorbs the beat that may be in flight when full asserts.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_tvalid/s_tready   stream handshake (s_tready registered)
//   s_tdata, s_tlast    stream payload and end-of-frame marker
//   full                FIFO full
//   wr_en, din          FIFO write strobe and data
//   frame_done          pulse on the FIFO write of a last beat
//   beat_cnt, frame_cnt running counts of beats and frames written

module axis_fifo #(
  parameter int C_DATA_W = 128,
  parameter int C_CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic [C_DATA_W-1:0] s_tdata,
  input  logic                s_tlast,
  input  logic                full,
  output logic                wr_en,
  output logic [C_DATA_W-1:0] din,
  output logic                frame_done,
  output logic [C_CNT_W-1:0]  beat_cnt,
  output logic [15:0]         frame_cnt
);

  localparam int N = C_DATA_W / 32;

  logic [C_DATA_W-1:0] swapped;
  logic                accept;
  logic                drain;
  logic                out_load;
  logic                skid_load;

  logic                out_valid;
  logic [C_DATA_W-1:0] out_data;
  logic                out_last;

  logic                skid_valid;
  logic                skid_valid_nxt;
  logic [C_DATA_W-1:0] skid_data;
  logic                skid_last;

  logic                ready_en;

  // Lane i of the input lands in lane N-1-i of the stored beat.
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign swapped[32*(N-1-g) +: 32] = s_tdata[32*g +: 32];
  end

  assign accept     = s_tvalid & s_tready;
  assign drain      = out_valid & ~full;
  assign wr_en      = drain;
  assign din        = out_data;
  assign frame_done = drain & out_last;

  // The output stage can take a new beat when it is empty or being written.
  assign out_load  = ~out_valid | drain;
  // A beat accepted while the output stage is stuck goes to the skid.
  assign skid_load = accept & out_valid & ~drain;

  // s_tready is registered as the inverse of the next skid state, so the
  // skid is always free whenever s_tready is high: accept and skid_valid
  // are never true together.
  always_comb begin
    skid_valid_nxt = skid_valid;
    if (out_load && skid_valid) begin
      skid_valid_nxt = 1'b0;
    end else if (skid_load) begin
      skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en   <= 1'b0;
      s_tready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      beat_cnt   <= '0;
      frame_cnt  <= '0;
    end else begin
      // ready_en delays s_tready by one extra edge after reset release.
      ready_en   <= 1'b1;
      s_tready   <= ready_en & ~skid_valid_nxt;
      skid_valid <= skid_valid_nxt;

      if (skid_load) begin
        skid_data <= swapped;
        skid_last <= s_tlast;
      end

      if (out_load) begin
        if (skid_valid) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          out_last  <= skid_last;
        end else if (accept) begin
          out_valid <= 1'b1;
          out_data  <= swapped;
          out_last  <= s_tlast;
        end else begin
          out_valid <= 1'b0;
        end
      end

      if (drain) begin
        beat_cnt <= beat_cnt + C_CNT_W'(1);
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_fifo.sv
// tb/tb_axis_fifo.sv - directed and randomized self-checking bench for axis_fifo

module tb_axis_fifo;

  logic         clk;
  logic         rst_n;
  logic         s_tvalid;
  logic         s_tready;
  logic [127:0] s_tdata;
  logic         s_tlast;
  logic         full;
  logic         wr_en;
  logic [127:0] din;
  logic         frame_done;
  logic [31:0]  beat_cnt;
  logic [15:0]  frame_cnt;

  logic         s_tready4;
  logic         wr_en4;
  logic [127:0] din4;
  logic         frame_done4;
  logic [3:0]   beat_cnt4;
  logic [15:0]  frame_cnt4;

  int n_checks;
  int n_fail;

  logic [127:0] exp_q[$];
  bit           exp_last_q[$];
  logic [127:0] got_q[$];
  bit           got_last_q[$];
  int           viol;
  int           run_len;
  int           max_run;
  int           stalls;

  axis_fifo #(.C_DATA_W(128), .C_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .full(full), .wr_en(wr_en),
    .din(din), .frame_done(frame_done), .beat_cnt(beat_cnt), .frame_cnt(frame_cnt)
  );

  axis_fifo #(.C_DATA_W(128), .C_CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(s_tready4),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .full(full), .wr_en(wr_en4),
    .din(din4), .frame_done(frame_done4), .beat_cnt(beat_cnt4), .frame_cnt(frame_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] lane_swap(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*(3-i) +: 32] = d[32*i +: 32];
    return r;
  endfunction

  // Records every FIFO write seen mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        got_q.push_back(din);
        got_last_q.push_back(frame_done);
        run_len = run_len + 1;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (wr_en && full) viol = viol + 1;
    end
  end

  task automatic clear_scoreboard();
    exp_q.delete();
    exp_last_q.delete();
    got_q.delete();
    got_last_q.delete();
    viol = 0;
    run_len = 0;
    max_run = 0;
    stalls = 0;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    full     = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_scoreboard();
  endtask

  // Holds s_tvalid with the beat until it is accepted; leaves s_tvalid high.
  task automatic send_beat(input logic [127:0] d, input bit last);
    int t;
    t = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    @(negedge clk);
    if (!s_tready) stalls = stalls + 1;
    while (!s_tready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!s_tready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: s_tready=%0b after %0d cycles, required 1", s_tready, t);
    end else begin
      @(posedge clk);
      #1;
      exp_q.push_back(lane_swap(d));
      exp_last_q.push_back(last);
    end
  endtask

  task automatic compare_streams(input string name);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d writes, required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        n_fail++;
        $display("FAIL %s_data[%0d]: got %h/%0b, required %h/%0b", name, i,
                 got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
        break;
      end
    end
  endtask

  task automatic test_reset();
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    full     = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({s_tready, wr_en, frame_done} !== 3'b000 || beat_cnt !== 32'd0 ||
        frame_cnt !== 16'd0 || din !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_values: tready=%0b wr_en=%0b fd=%0b beat=%0d frame=%0d din=%h, required all 0",
               s_tready, wr_en, frame_done, beat_cnt, frame_cnt, din);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (s_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_edge1: s_tready=%0b, required 0", s_tready);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_edge2: s_tready=%0b, required 1", s_tready);
    end
    clear_scoreboard();
  endtask

  task automatic test_single_beat();
    do_reset();
    s_tvalid = 1'b1;
    s_tdata  = 128'h00000004_00000003_00000002_00000001;
    s_tlast  = 1'b1;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b1 || frame_done !== 1'b1 ||
        din !== 128'h00000001_00000002_00000003_00000004) begin
      n_fail++;
      $display("FAIL single_write: wr_en=%0b fd=%0b din=%h, required 1 1 00000001000000020000000300000004",
               wr_en, frame_done, din);
    end
    @(negedge clk);
    n_checks++;
    if (beat_cnt !== 32'd1 || frame_cnt !== 16'd1 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_counts: beat=%0d frame=%0d wr_en=%0b, required 1 1 0",
               beat_cnt, frame_cnt, wr_en);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      send_beat({32'(4*k+3), 32'(4*k+2), 32'(4*k+1), 32'(4*k)}, k == 15);
    end
    s_tvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    compare_streams("stream");
    n_checks++;
    if (max_run !== 16) begin
      n_fail++;
      $display("FAIL stream_consecutive: longest wr_en run %0d, required 16", max_run);
    end
    n_checks++;
    if (stalls !== 0) begin
      n_fail++;
      $display("FAIL stream_tready: %0d stalls, required 0", stalls);
    end
    n_checks++;
    if (beat_cnt !== 32'd16 || frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL stream_counts: beat=%0d frame=%0d, required 16 1", beat_cnt, frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    int n0;
    do_reset();
    fork
      begin
        for (int k = 0; k < 20; k++) send_beat({4{32'(32'hA000 + k)}} ^ 128'(k), k == 19);
        s_tvalid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        full = 1'b1;
        n0 = got_q.size();
        repeat (10) @(negedge clk);
        n_checks++;
        if (s_tready !== 1'b0 || wr_en !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_hold: s_tready=%0b wr_en=%0b, required 0 0", s_tready, wr_en);
        end
        n_checks++;
        if (got_q.size() !== n0) begin
          n_fail++;
          $display("FAIL bp_no_write: %0d writes while full, required 0", got_q.size() - n0);
        end
        n_checks++;
        if (exp_q.size() - got_q.size() !== 2) begin
          n_fail++;
          $display("FAIL bp_buffered: %0d beats buffered, required 2", exp_q.size() - got_q.size());
        end
        @(posedge clk);
        #1;
        full = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    compare_streams("bp");
    n_checks++;
    if (viol !== 0 || beat_cnt !== 32'd20) begin
      n_fail++;
      $display("FAIL bp_counts: viol=%0d beat=%0d, required 0 20", viol, beat_cnt);
    end
  endtask

  task automatic test_random();
    bit done;
    int n_last;
    do_reset();
    done = 1'b0;
    n_last = 0;
    fork
      begin
        for (int k = 0; k < 10000; k++) begin
          bit l;
          if ($urandom_range(3) == 0) begin
            s_tvalid = 1'b0;
            repeat ($urandom_range(2, 1)) @(posedge clk);
            #1;
          end
          l = ($urandom_range(3) == 0);
          if (l) n_last++;
          send_beat({$urandom, $urandom, $urandom, $urandom}, l);
        end
        s_tvalid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          full = $urandom_range(1);
        end
        full = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    compare_streams("rand");
    n_checks++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL rand_full_write: %0d writes while full, required 0", viol);
    end
    n_checks++;
    if (beat_cnt !== 32'd10000 || frame_cnt !== 16'(n_last)) begin
      n_fail++;
      $display("FAIL rand_counts: beat=%0d frame=%0d, required 10000 %0d", beat_cnt, frame_cnt, n_last);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    s_tvalid = 1'b1;
    s_tdata  = 128'h11111111_22222222_33333333_44444444;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    full = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    n_checks++;
    if (s_tready !== 1'b0 || beat_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL midrst_pre: s_tready=%0b beat=%0d, required 0 2", s_tready, beat_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_tready, wr_en, frame_done} !== 3'b000 || beat_cnt !== 32'd0 ||
        frame_cnt !== 16'd0 || din !== 128'd0) begin
      n_fail++;
      $display("FAIL midrst_async: tready=%0b wr_en=%0b fd=%0b beat=%0d frame=%0d din=%h, required all 0",
               s_tready, wr_en, frame_done, beat_cnt, frame_cnt, din);
    end
    full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (s_tready !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_edge1: s_tready=%0b wr_en=%0b, required 0 0", s_tready, wr_en);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (s_tready !== 1'b1 || wr_en !== 1'b0 || beat_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_edge2: s_tready=%0b wr_en=%0b beat=%0d, required 1 0 0", s_tready, wr_en, beat_cnt);
    end
    clear_scoreboard();
    send_beat(128'h1, 1'b1);
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (beat_cnt !== 32'd1 || frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL midrst_restart: beat=%0d frame=%0d, required 1 1", beat_cnt, frame_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 17; k++) send_beat(128'(k), 1'b0);
    s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (beat_cnt4 !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap_cnt4: beat_cnt=%0d, required 1", beat_cnt4);
    end
    n_checks++;
    if (beat_cnt !== 32'd17) begin
      n_fail++;
      $display("FAIL wrap_cnt32: beat_cnt=%0d, required 17", beat_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_scoreboard();
    test_reset();
    test_single_beat();
    test_streaming();
    test_backpressure();
    test_random();
    test_reset_mid_frame();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
